// File: rtl/fp_round_pack_pkg.sv
// Shared types and widths for the round-and-pack stage.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Holds the FSM state enum and the exponent/significand widths used by
// fp_round_pack and fp_round_add.
package fp_round_pack_pkg;

    localparam int EXP_W = 3;
    localparam int SIG_W = 4;

    localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/fp_round_add.sv
// Adds the round bit into the truncated significand and reports carry-out.
// Latency: combinational.
// Backpressure: n/a (pure logic).
//
// Ports:
//   sig_in   - truncated significand
//   rnd_in   - round bit, the first bit below sig_in
//   sum_out  - low SIG_W bits of sig_in + rnd_in
//   carry    - carry-out of the addition (significand overflowed)
module fp_round_add
    import fp_round_pack_pkg::*;
(
    input  logic [SIG_W-1:0] sig_in,
    input  logic             rnd_in,
    output logic [SIG_W-1:0] sum_out,
    output logic             carry
);

    always_comb begin
        {carry, sum_out} = {1'b0, sig_in} + {{SIG_W{1'b0}}, rnd_in};
    end

endmodule

// File: rtl/fp_round_pack.sv
// Rounds a sign/exponent/significand result to nearest (round bit add) and packs it, saturating at max magnitude.
// Latency: out_valid rises 2 edges after acceptance without carry, 3 edges with carry.
// Backpressure: one result in flight; in_ready low until the packed result is taken with out_ready.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_ready        - upstream handshake; S_in, E_in, F_in, R_in captured on accept
//   out_valid/out_ready      - downstream handshake; S, E, F, sat held while out_valid=1
//   sat                      - result clamped to maximum magnitude
module fp_round_pack
    import fp_round_pack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             S_in,
    input  logic [EXP_W-1:0] E_in,
    input  logic [SIG_W-1:0] F_in,
    input  logic             R_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             S,
    output logic [EXP_W-1:0] E,
    output logic [SIG_W-1:0] F,
    output logic             sat
);

    localparam logic [EXP_W-1:0] EXP_ONE  = 1;
    localparam logic [SIG_W-1:0] SIG_HALF = {1'b1, {(SIG_W-1){1'b0}}};
    localparam logic [SIG_W-1:0] SIG_ONES = {SIG_W{1'b1}};

    state_e state_q, state_d;

    // Captured operand
    logic             s_q, s_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic [SIG_W-1:0] f_q, f_d;
    logic             r_q, r_d;

    // The adder result is registered on the first ADD cycle so the carry
    // decision on the second ADD cycle comes straight from a flop.
    logic [SIG_W:0]   sum_q, sum_d;
    logic             sum_vld_q, sum_vld_d;

    // Packed output registers
    logic             out_s_q, out_s_d;
    logic [EXP_W-1:0] out_e_q, out_e_d;
    logic [SIG_W-1:0] out_f_q, out_f_d;
    logic             out_sat_q, out_sat_d;

    logic [SIG_W-1:0] add_sum;
    logic             add_carry;

    fp_round_add u_add (
        .sig_in  (f_q),
        .rnd_in  (r_q),
        .sum_out (add_sum),
        .carry   (add_carry)
    );

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        e_d       = e_q;
        f_d       = f_q;
        r_d       = r_q;
        sum_d     = sum_q;
        sum_vld_d = sum_vld_q;
        out_s_d   = out_s_q;
        out_e_d   = out_e_q;
        out_f_d   = out_f_q;
        out_sat_d = out_sat_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d       = S_in;
                    e_d       = E_in;
                    f_d       = F_in;
                    r_d       = R_in;
                    sum_vld_d = 1'b0;
                    state_d   = ADD;
                end
            end
            ADD: begin
                if (!sum_vld_q) begin
                    sum_d     = {add_carry, add_sum};
                    sum_vld_d = 1'b1;
                end else if (!sum_q[SIG_W]) begin
                    // No overflow: rounded significand fits, exponent as-is.
                    out_s_d   = s_q;
                    out_e_d   = e_q;
                    out_f_d   = sum_q[SIG_W-1:0];
                    out_sat_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    state_d   = ADJ;
                end
            end
            ADJ: begin
                out_s_d = s_q;
                if (e_q != EXP_MAX) begin
                    // Significand overflowed to 10000: renormalise to 1000, bump exponent.
                    out_e_d   = e_q + EXP_ONE;
                    out_f_d   = SIG_HALF;
                    out_sat_d = 1'b0;
                end else begin
                    // No exponent headroom: clamp to the largest magnitude.
                    out_e_d   = EXP_MAX;
                    out_f_d   = SIG_ONES;
                    out_sat_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= 1'b0;
            e_q       <= '0;
            f_q       <= '0;
            r_q       <= 1'b0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            out_s_q   <= 1'b0;
            out_e_q   <= '0;
            out_f_q   <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            e_q       <= e_d;
            f_q       <= f_d;
            r_q       <= r_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
            out_s_q   <= out_s_d;
            out_e_q   <= out_e_d;
            out_f_q   <= out_f_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = out_s_q;
    assign E         = out_e_q;
    assign F         = out_f_q;
    assign sat       = out_sat_q;

endmodule
